// File: rtl/pilha_param.sv
// Parametrised LIFO stack with top-of-stack peek, replace (push+pop), flush,
// almost-full threshold, sticky overflow/underflow flags and a high-water mark.
module pilha_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 1,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic [DATA_W-1:0] top,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow,
    output logic [CW-1:0]     high_water
);

    localparam int IW = $clog2(DEPTH);
    localparam logic AFULL_RST = (AFULL_LVL == 0) ? 1'b1 : 1'b0;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [CW-1:0]     count_r;
    logic [DATA_W-1:0] data_out_r;
    logic              dov_r;
    logic              ovf_r;
    logic              udf_r;
    logic [CW-1:0]     hw_r;
    logic              empty_r;
    logic              full_r;
    logic              afull_r;

    logic [CW-1:0]     count_nxt_s;
    logic [DATA_W-1:0] dout_nxt_s;
    logic              dov_nxt_s;
    logic              ovf_set_s;
    logic              udf_set_s;
    logic              wr_en_s;
    logic [IW-1:0]     wr_idx_s;
    logic [IW-1:0]     top_idx_s;
    logic [CW-1:0]     hw_base_s;
    logic [CW-1:0]     hw_nxt_s;

    assign top_idx_s = IW'(count_r - CW'(1));

    // Next-state decode: flush beats push/pop; push+pop is a replace (or bypass when empty)
    always_comb begin
        count_nxt_s = count_r;
        dout_nxt_s  = data_out_r;
        dov_nxt_s   = 1'b0;
        ovf_set_s   = 1'b0;
        udf_set_s   = 1'b0;
        wr_en_s     = 1'b0;
        wr_idx_s    = IW'(count_r);
        if (flush) begin
            count_nxt_s = {CW{1'b0}};
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!empty_r && full_r) begin
                        ovf_set_s = 1'b1;
                    end else if (full_r) begin
                        ovf_set_s = 1'b1;
                    end else begin
                        wr_en_s     = 1'b1;
                        count_nxt_s = count_r + CW'(1);
                    end
                end
                2'b01: begin
                    if (empty_r) begin
                        udf_set_s = 1'b1;
                    end else begin
                        dout_nxt_s  = mem_r[top_idx_s];
                        dov_nxt_s   = 1'b1;
                        count_nxt_s = count_r - CW'(1);
                    end
                end
                2'b11: begin
                    dov_nxt_s = 1'b1;
                    if (empty_r) begin
                        dout_nxt_s = data_in;
                    end else begin
                        dout_nxt_s = mem_r[top_idx_s];
                        wr_en_s    = 1'b1;
                        wr_idx_s   = top_idx_s;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // High-water tracking: clr_err restarts from the count being produced this cycle
    always_comb begin
        if (clr_err) begin
            hw_base_s = {CW{1'b0}};
        end else begin
            hw_base_s = hw_r;
        end
        if (count_nxt_s > hw_base_s) begin
            hw_nxt_s = count_nxt_s;
        end else begin
            hw_nxt_s = hw_base_s;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= data_in;
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r    <= {CW{1'b0}};
            data_out_r <= {DATA_W{1'b0}};
            dov_r      <= 1'b0;
            ovf_r      <= 1'b0;
            udf_r      <= 1'b0;
            hw_r       <= {CW{1'b0}};
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            afull_r    <= AFULL_RST;
        end else begin
            count_r    <= count_nxt_s;
            data_out_r <= dout_nxt_s;
            dov_r      <= dov_nxt_s;
            ovf_r      <= ovf_set_s | (ovf_r & ~clr_err);
            udf_r      <= udf_set_s | (udf_r & ~clr_err);
            hw_r       <= hw_nxt_s;
            empty_r    <= (count_nxt_s == {CW{1'b0}});
            full_r     <= (count_nxt_s == CW'(DEPTH));
            afull_r    <= (count_nxt_s >= CW'(AFULL_LVL));
        end
    end

    assign top            = empty_r ? {DATA_W{1'b0}} : mem_r[top_idx_s];
    assign data_out       = data_out_r;
    assign data_out_valid = dov_r;
    assign count          = count_r;
    assign empty          = empty_r;
    assign full           = full_r;
    assign almost_full    = afull_r;
    assign overflow       = ovf_r;
    assign underflow      = udf_r;
    assign high_water     = hw_r;

endmodule

// File: tb/tb_pilha_param.sv
// Self-checking bench for pilha_param: directed scenarios plus random traffic
// against a queue-based reference model of the stack.
module tb_pilha_param;

    localparam int DW  = 8;
    localparam int DEP = 4;
    localparam int AFL = 3;
    localparam int CW  = $clog2(DEP + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          push = 1'b0, pop = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] data_in = 8'h00;
    logic [DW-1:0] data_out, top;
    logic          data_out_valid, empty, full, almost_full, overflow, underflow;
    logic [CW-1:0] count, high_water;

    pilha_param #(.DATA_W(DW), .DEPTH(DEP), .AFULL_LVL(AFL)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
        .clr_err(clr_err), .data_in(data_in), .data_out(data_out),
        .data_out_valid(data_out_valid), .top(top), .count(count),
        .empty(empty), .full(full), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow), .high_water(high_water)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = 8'h00;
    logic          m_dov = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
    int            m_hw = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = 8'h00; m_dov = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_hw = 0;
    endtask

    task automatic model_step(input logic pu, input logic po, input logic fl,
                              input logic ce, input logic [DW-1:0] d);
        logic os, us;
        os = 1'b0; us = 1'b0; m_dov = 1'b0;
        if (fl) begin
            q.delete();
        end else if (pu && po) begin
            m_dov = 1'b1;
            if (q.size() > 0) begin
                m_dout = q[q.size()-1];
                q[q.size()-1] = d;
            end else begin
                m_dout = d;
            end
        end else if (pu) begin
            if (q.size() < DEP) q.push_back(d);
            else os = 1'b1;
        end else if (po) begin
            if (q.size() > 0) begin
                m_dout = q.pop_back();
                m_dov = 1'b1;
            end else begin
                us = 1'b1;
            end
        end
        m_ovf = os | (m_ovf & ~ce);
        m_udf = us | (m_udf & ~ce);
        if (ce) m_hw = 0;
        if (q.size() > m_hw) m_hw = q.size();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEP));
        chk({tag, ".afull"}, 32'(almost_full), 32'(q.size() >= AFL));
        chk({tag, ".top"}, 32'(top), (q.size() > 0) ? 32'(q[q.size()-1]) : 32'd0);
        chk({tag, ".dout"}, 32'(data_out), 32'(m_dout));
        chk({tag, ".dov"}, 32'(data_out_valid), 32'(m_dov));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
        chk({tag, ".hw"}, 32'(high_water), 32'(m_hw));
    endtask

    task automatic step(input string tag, input logic pu, input logic po, input logic fl,
                        input logic ce, input logic [DW-1:0] d);
        push = pu; pop = po; flush = fl; clr_err = ce; data_in = d;
        @(posedge clk);
        #1;
        model_step(pu, po, fl, ce, d);
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [DW-1:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_held");
        reset = 1'b1;
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // fill to full, then overflow
        for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b0, 1'b0, 1'b0, vals[i]);
        chk("full_top", 32'(top), 32'h44);
        chk("full_hw", 32'(high_water), 32'd4);
        step("ovf", 1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        chk("ovf_flag", 32'(overflow), 32'd1);

        // drain, then underflow
        for (int i = 0; i < 4; i++) begin
            step("drain", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk("drain_val", 32'(data_out), 32'(vals[3-i]));
        end
        step("udf", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("udf_hold", 32'(data_out), 32'h11);

        // replace and bypass
        step("clr0", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        step("p1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        step("p2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
        step("repl", 1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
        chk("repl_dout", 32'(data_out), 32'h22);
        chk("repl_top", 32'(top), 32'h99);
        step("e1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step("e2", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step("clr1", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        step("bypass", 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
        chk("bypass_dout", 32'(data_out), 32'h5A);
        chk("bypass_udf", 32'(underflow), 32'd0);

        // flush with push, then clear, then clear+underflow
        for (int i = 0; i < 3; i++) step("f_fill", 1'b1, 1'b0, 1'b0, 1'b0, vals[i]);
        step("flush", 1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
        chk("flush_hw", 32'(high_water), 32'd3);
        step("clr2", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        step("clr_udf", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("clr_udf_flag", 32'(underflow), 32'd1);

        // asynchronous reset mid-sequence
        step("r1", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA1);
        step("r2", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA2);
        step("r3", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA3);
        step("r4", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        reset = 1'b1;
        step("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic pu, po, fl, ce;
            pu = ($urandom_range(0, 99) < 50);
            po = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 99) < 4);
            ce = ($urandom_range(0, 99) < 6);
            step("rnd", pu, po, fl, ce, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pilha_param.md
Name: pilha_param

Overview:
Parametrised LIFO stack, the next generation of the processor's 8-level call/data stack. It adds configurable width and depth, a combinational top-of-stack peek, and simultaneous push+pop (replace top). It also provides flush, an almost-full threshold, sticky overflow/underflow error flags and a high-water mark. The control unit uses it for JUMP/RETURN linkage, and it is also available as a general operand stack.

Parameters:
DATA_W, 8, width of each stack entry in bits (>=1)
DEPTH, 8, number of entries (>=2; power of two not required)
AFULL_LVL, DEPTH-1, count at or above which almost_full asserts (1..DEPTH)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
push  in  1  push data_in this cycle
pop  in  1  pop top entry this cycle
flush  in  1  empty the stack synchronously
clr_err  in  1  clear overflow, underflow and high_water
data_in  in  DATA_W  value to push
data_out  out  DATA_W  registered popped value
data_out_valid  out  1  one-cycle pulse: data_out updated by a pop
top  out  DATA_W  current top entry (combinational from state), 0 when empty
count  out  CW=$clog2(DEPTH+1)  number of valid entries
empty  out  1  count==0
full  out  1  count==DEPTH
almost_full  out  1  count>=AFULL_LVL
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty
high_water  out  CW  maximum count reached since reset/clr_err

Behaviour:
- Reset (reset low, asynchronous): count=0, data_out=0, data_out_valid=0, overflow=0, underflow=0, high_water=0, therefore empty=1, full=0, almost_full=0 (or 1 if AFULL_LVL==0, which is illegal). Storage array is not reset. Deassertion is taken synchronously to clk.
- Storage is internal memory mem[0..DEPTH-1]. Entry i is valid for i<count. The top entry is mem[count-1].
- empty, full and almost_full are decoded from registered count, so there is no combinational path from push/pop inputs.
- top = mem[count-1] when count>0, else 0. It reflects the state after the last clock edge.
- Per-cycle priority: flush, then push/pop.
  - flush=1: count<=0 and data_out_valid<=0. push/pop are ignored that cycle and raise no error. data_out and the error flags hold. clr_err still acts.
- push=1, pop=0:
  - If !full: mem[count]<=data_in, count<=count+1.
  - If full: data dropped, count unchanged, overflow<=1.
- pop=1, push=0:
  - If !empty: data_out<=mem[count-1], data_out_valid<=1, count<=count-1.
  - If empty: underflow<=1, data_out holds, data_out_valid<=0.
- push=1, pop=1:
  - If !empty: data_out<=mem[count-1], data_out_valid<=1, mem[count-1]<=data_in, count unchanged. This is a replace, legal when full, and raises no overflow.
  - If empty: bypass. data_out<=data_in, data_out_valid<=1, count stays 0, no underflow.
- data_out_valid is high exactly one cycle per successful pop. data_out holds its last value otherwise.
- Latency: a pushed value appears on top one cycle after the push edge. A popped value appears on data_out one cycle after the pop edge.
- high_water updates to max(high_water, next count) every cycle.
- clr_err=1 clears overflow, underflow and high_water. If an error or a new count is produced in the same cycle, the new event wins: the flag sets, and high_water loads the next count.
- count never wraps. Saturation is enforced by the full/empty checks above.

Test Plan:
- Reset then idle, with DATA_W=8, DEPTH=4, AFULL_LVL=3 -> count=0, empty=1, full=0, top=0, all flags 0, data_out=0.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count 1,2,3,4; almost_full rises when count=3; full=1 at count=4; top=0x44; high_water=4. A fifth push of 0x55 -> overflow=1, count=4, top=0x44.
- Pop four times from full -> data_out 0x44, 0x33, 0x22, 0x11, each with a one-cycle data_out_valid pulse; empty=1 after the fourth. A fifth pop -> underflow=1, data_out stays 0x11, no valid pulse.
- Stack holding {0x11, 0x22}, push+pop with data_in=0x99 -> data_out=0x22 with valid, count=2, top=0x99. On an empty stack, push+pop with 0x5A -> data_out=0x5A with valid, count=0, no error.
- Stack at count=3, flush asserted together with push -> count=0 next cycle, no overflow, and high_water keeps 3. Then clr_err -> high_water=0, flags 0. clr_err together with a pop on empty -> underflow=1.
- reset pulsed low mid-sequence, at count=2 between clock edges -> count=0, data_out_valid=0 and flags 0 immediately, without waiting for clk.
